// File: rtl/toggle_pulse_gen.sv
// Debounced push-button to single-cycle toggle pulse, with press counter.
// Define TOGGLE_REPEAT_EN to emit auto-repeat pulses while the button stays held.
module toggle_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_CYCLES   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  output logic       t,
  output logic       pressed,
  output logic [7:0] press_count
);

  localparam int CNT_MAX = ((DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES
                                                               : REPEAT_CYCLES) - 1;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef TOGGLE_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS_WAIT,
    S_HELD,
    S_REL_WAIT
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sync1;
  logic             r_btn_s;
  logic             r_t;
  logic             r_pressed;
  logic [7:0]       r_press_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_sync1       <= 1'b0;
      r_btn_s       <= 1'b0;
      r_t           <= 1'b0;
      r_pressed     <= 1'b0;
      r_press_count <= 8'd0;
    end else begin
      r_sync1 <= btn_in;
      r_btn_s <= r_sync1;
      r_t     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_btn_s) begin
            r_state <= S_PRESS_WAIT;
            r_cnt   <= '0;
          end
        end
        S_PRESS_WAIT: begin
          if (!r_btn_s) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == DEB_LAST) begin
            r_state       <= S_HELD;
            r_cnt         <= '0;
            r_t           <= 1'b1;
            r_pressed     <= 1'b1;
            r_press_count <= r_press_count + 8'd1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_HELD: begin
          if (!r_btn_s) begin
            r_state <= S_REL_WAIT;
            r_cnt   <= '0;
          end
`ifdef TOGGLE_REPEAT_EN
          // Repeat period counts from the previous pulse edge.
          else if (r_cnt == REP_LAST) begin
            r_cnt         <= '0;
            r_t           <= 1'b1;
            r_press_count <= r_press_count + 8'd1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        S_REL_WAIT: begin
          if (r_btn_s) begin
            r_state <= S_HELD;
            r_cnt   <= '0;
          end else if (r_cnt == DEB_LAST) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_pressed <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_cnt     <= '0;
          r_pressed <= 1'b0;
        end
      endcase
    end
  end

  assign t           = r_t;
  assign pressed     = r_pressed;
  assign press_count = r_press_count;

endmodule
